// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//   Boot-time controller that fills instruction memory from an 8-bit byte
//   stream and then releases the core from reset. The stream format is a
//   4-byte little-endian word count N, N little-endian 32-bit words, and an
//   8-bit additive checksum over the data bytes.
//
// Ports
//   clk        in   clock
//   reset      in   asynchronous active-low reset
//   boot_mode  in   sampled in IDLE: 1 = load an image, 0 = run existing image
//   load_req   in   single-cycle pulse, starts a reload from RUN or ERR
//   rx_valid   in   byte available
//   rx_data    in   byte value
//   rx_ready   out  loader accepts a byte (registered state decode)
//   imem_we    out  instruction-memory write strobe (one cycle per word)
//   imem_addr  out  word address, holds its last value between writes
//   imem_wdata out  write data
//   core_reset out  active-high core reset, low only in RUN
//   done       out  last load completed successfully
//   error      out  last load failed
// -----------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int  IMEM_WORDS     = 1024,
  parameter int  TIMEOUT_CYCLES = 1000000,
  localparam int AW             = $clog2(IMEM_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          boot_mode,
  input  logic          load_req,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          core_reset,
  output logic          done,
  output logic          error
);

  localparam logic [31:0] MAX_WORDS = 32'(IMEM_WORDS);
  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    byte_cnt_q;
  logic [31:0]   len_q;
  logic [31:0]   word_q;
  logic [7:0]    csum_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   tmo_q;

  logic          rx_ready_q;
  logic          imem_we_q;
  logic [AW-1:0] imem_addr_q;
  logic [31:0]   imem_wdata_q;
  logic          core_reset_q;
  logic          done_q;
  logic          error_q;

  logic          accept_s;
  logic          loading_s;
  logic          len_bad_s;
  logic          last_word_s;
  logic          tmo_hit_s;
  logic [31:0]   len_next_s;
  logic [31:0]   word_next_s;

  // rx_ready is a flop, so rx_valid never reaches it combinationally.
  assign accept_s    = rx_valid & rx_ready_q;
  assign loading_s   = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  // Little-endian assembly: each new byte enters at the top and the first
  // byte ends up in bits 7:0 after four shifts.
  assign len_next_s  = {rx_data, len_q[31:8]};
  assign word_next_s = {rx_data, word_q[31:8]};
  assign len_bad_s   = (len_next_s == 32'd0) || (len_next_s > MAX_WORDS);
  assign last_word_s = (32'(idx_q) == (len_q - 32'd1));
  // tmo_q counts completed idle cycles; the current cycle is the limit-th one
  // when tmo_q equals limit-1. A byte accepted in that cycle still wins.
  assign tmo_hit_s   = (TMO_LIMIT != 32'd0) && (tmo_q == (TMO_LIMIT - 32'd1));

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign error      = error_q;

  // Next-state decision for the load sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (boot_mode) state_d = ST_LEN;
        else           state_d = ST_RUN;
      end
      ST_LEN: begin
        if (accept_s && (byte_cnt_q == 2'd3)) state_d = len_bad_s ? ST_ERR : ST_DATA;
        else if (!accept_s && tmo_hit_s)      state_d = ST_ERR;
        else                                  state_d = ST_LEN;
      end
      ST_DATA: begin
        if (accept_s && (byte_cnt_q == 2'd3) && last_word_s) state_d = ST_CSUM;
        else if (!accept_s && tmo_hit_s)                     state_d = ST_ERR;
        else                                                 state_d = ST_DATA;
      end
      ST_CSUM: begin
        if (accept_s)        state_d = (rx_data == csum_q) ? ST_RUN : ST_ERR;
        else if (tmo_hit_s)  state_d = ST_ERR;
        else                 state_d = ST_CSUM;
      end
      ST_RUN: begin
        if (load_req) state_d = ST_LEN;
        else          state_d = ST_RUN;
      end
      ST_ERR: begin
        if (load_req) state_d = ST_LEN;
        else          state_d = ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      byte_cnt_q   <= 2'd0;
      len_q        <= 32'd0;
      word_q       <= 32'd0;
      csum_q       <= 8'd0;
      idx_q        <= '0;
      tmo_q        <= 32'd0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      // Outputs are decoded from the next state so they line up with it.
      rx_ready_q   <= (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
      core_reset_q <= (state_d != ST_RUN);
      error_q      <= (state_d == ST_ERR);
      // done rises on CSUM->RUN, holds in RUN, and clears on any other state.
      done_q       <= (state_d == ST_RUN) && (done_q || (state_q == ST_CSUM));
      imem_we_q    <= 1'b0;

      if ((state_d != state_q) || accept_s || !loading_s || (TMO_LIMIT == 32'd0)) begin
        tmo_q <= 32'd0;
      end else begin
        tmo_q <= tmo_q + 32'd1;
      end

      case (state_q)
        ST_LEN: begin
          if (accept_s) begin
            len_q      <= len_next_s;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            idx_q      <= '0;
            csum_q     <= 8'd0;
          end
        end
        ST_DATA: begin
          if (accept_s) begin
            word_q     <= word_next_s;
            csum_q     <= csum_q + rx_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= idx_q;
              imem_wdata_q <= word_next_s;
              // Stop at the last word so an image of exactly IMEM_WORDS
              // never pushes the index past its range.
              if (!last_word_s) idx_q <= idx_q + AW'(1);
            end
          end
        end
        default: begin
        end
      endcase

      // A timeout mid-length or mid-word must not leave a stale byte phase.
      if (state_d != state_q) byte_cnt_q <= 2'd0;
    end
  end

endmodule
